// File: rtl/sgd_pkg.sv
// rtl/sgd_pkg.sv - FSM states, field geometry and Q-format arithmetic helpers (SGD_SATURATE_EN selects saturating adds)
package sgd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADW,
        S_FETCH,
        S_PRED,
        S_UPDATE,
        S_DONE
    } state_t;

    // Scratch width for sums and products; word widths up to 32 bits fit without loss.
    localparam int CALC_W = 64;

`ifdef SGD_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // Field 0 sits in the most significant slot of a packed word.
    function automatic int field_lsb(input int idx, input int len, input int nfields);
        return len * (nfields - 1 - idx);
    endfunction

    function automatic logic signed [CALC_W-1:0] sat_add(
        input logic signed [CALC_W-1:0] a,
        input logic signed [CALC_W-1:0] b,
        input int                       w,
        input bit                       sat
    );
        logic signed [CALC_W-1:0] s;
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (sat) begin
            if (s > hi) return hi;
            if (s < lo) return lo;
            return s;
        end
        return (s <<< (CALC_W - w)) >>> (CALC_W - w);
    endfunction

    function automatic logic signed [CALC_W-1:0] trunc_q(
        input logic signed [CALC_W-1:0] p,
        input int                       frac
    );
        return p >>> frac;
    endfunction

endpackage

// File: rtl/sgd_mul.sv
// rtl/sgd_mul.sv - signed fixed-point multiply, full product shifted right by FRAC, low LENGTH bits kept
module sgd_mul
    import sgd_pkg::*;
#(
    parameter int LENGTH = 16,
    parameter int FRAC   = 8
) (
    input  logic signed [LENGTH-1:0] a,
    input  logic signed [LENGTH-1:0] b,
    output logic signed [LENGTH-1:0] p
);

    logic signed [2*LENGTH-1:0] full;

    assign full = a * b;
    assign p    = LENGTH'(trunc_q(CALC_W'(full), FRAC));

endmodule

// File: rtl/sgd_trainer_v4.sv
// rtl/sgd_trainer_v4.sv - streaming linear-regression SGD trainer; SGD_SATURATE_EN makes the adds saturate
module sgd_trainer_v4
    import sgd_pkg::*;
#(
    parameter int LENGTH       = 16,
    parameter int FRAC         = 8,
    parameter int MAX_FEATURES = 15,
    parameter int ADDR_WIDTH   = 12
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [$clog2(MAX_FEATURES+1)-1:0]    feat,
    input  logic [ADDR_WIDTH-1:0]                data_points,
    input  logic [7:0]                           epoch,
    input  logic [3:0]                           learn_rate,
    input  logic [LENGTH*(MAX_FEATURES+1)-1:0]   s_data,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    output logic [ADDR_WIDTH-1:0]                addr,
    input  logic [$clog2(MAX_FEATURES+1)-1:0]    w_sel,
    output logic [LENGTH-1:0]                    w_rdata,
    output logic                                 busy,
    output logic                                 done,
    output logic [LENGTH-1:0]                    err_out
);

    localparam int NF = MAX_FEATURES + 1;
    localparam int SW = $clog2(MAX_FEATURES + 1);

    state_t state, state_n;

    logic [SW-1:0]         feat_r;
    logic [ADDR_WIDTH-1:0] dp_r;
    logic [7:0]            ep_r;
    logic [3:0]            lr_r;
    logic [7:0]            epoch_cnt;

    logic signed [LENGTH-1:0] w      [NF];
    logic signed [LENGTH-1:0] w_upd  [NF];
    logic signed [LENGTH-1:0] field  [NF];
    logic signed [LENGTH-1:0] x_r    [1:MAX_FEATURES];
    logic signed [LENGTH-1:0] mul_b  [1:MAX_FEATURES];
    logic signed [LENGTH-1:0] prod   [1:MAX_FEATURES];
    logic [MAX_FEATURES:1]    lane_on;
    logic signed [LENGTH-1:0] y_r;
    logic signed [LENGTH-1:0] yhat;
    logic signed [LENGTH-1:0] err_calc;
    logic signed [LENGTH-1:0] err_s;

    logic sample_last;
    logic epoch_last;

    assign err_s       = err_out;
    assign sample_last = (addr == dp_r);
    assign epoch_last  = ((epoch_cnt + 8'd1) == ep_r);

    genvar gj;
    generate
        for (gj = 0; gj < NF; gj++) begin : g_field
            localparam int LSB = field_lsb(gj, LENGTH, NF);
            assign field[gj] = s_data[LSB +: LENGTH];
        end

        // One multiplier per lane: weight operand while predicting, error operand while updating.
        for (gj = 1; gj <= MAX_FEATURES; gj++) begin : g_lane
            assign lane_on[gj] = (SW'(gj) <= feat_r);
            assign mul_b[gj]   = (state == S_UPDATE) ? err_s : w[gj];
            sgd_mul #(
                .LENGTH (LENGTH),
                .FRAC   (FRAC)
            ) u_mul (
                .a (x_r[gj]),
                .b (mul_b[gj]),
                .p (prod[gj])
            );
        end
    endgenerate

    always_comb begin
        yhat = w[0];
        for (int k = 1; k <= MAX_FEATURES; k++) begin
            if (lane_on[k]) begin
                yhat = LENGTH'(sat_add(CALC_W'(yhat), CALC_W'(prod[k]), LENGTH, SAT_EN));
            end
        end
        err_calc = LENGTH'(sat_add(CALC_W'(y_r), -CALC_W'(yhat), LENGTH, SAT_EN));
    end

    always_comb begin
        w_upd[0] = LENGTH'(sat_add(CALC_W'(w[0]), CALC_W'(err_s >>> lr_r), LENGTH, SAT_EN));
        for (int k = 1; k <= MAX_FEATURES; k++) begin
            w_upd[k] = w[k];
            if (lane_on[k]) begin
                w_upd[k] = LENGTH'(sat_add(CALC_W'(w[k]), CALC_W'(prod[k] >>> lr_r), LENGTH, SAT_EN));
            end
        end
    end

    assign w_rdata = (w_sel <= SW'(MAX_FEATURES)) ? w[w_sel] : '0;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        s_ready = 1'b0;
        busy    = !((state == S_IDLE) || (state == S_DONE));
        done    = (state == S_DONE);
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_n = S_LOADW;
            end
            S_LOADW: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    state_n = ((ep_r == 8'd0) || (dp_r == '0)) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                s_ready = 1'b1;
                if (s_valid) state_n = S_PRED;
            end
            S_PRED: begin
                state_n = S_UPDATE;
            end
            S_UPDATE: begin
                state_n = (sample_last && epoch_last) ? S_DONE : S_FETCH;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        if (abort) state_n = S_IDLE;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            feat_r    <= '0;
            dp_r      <= '0;
            ep_r      <= '0;
            lr_r      <= '0;
            epoch_cnt <= '0;
            addr      <= '0;
            err_out   <= '0;
            y_r       <= '0;
            for (int j = 0; j < NF; j++) w[j] <= '0;
            for (int k = 1; k <= MAX_FEATURES; k++) x_r[k] <= '0;
        end else if (abort) begin
            addr <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        feat_r    <= feat;
                        dp_r      <= data_points;
                        ep_r      <= epoch;
                        lr_r      <= learn_rate;
                        epoch_cnt <= '0;
                        addr      <= '0;
                    end
                end
                S_LOADW: begin
                    if (s_valid) begin
                        for (int j = 0; j < NF; j++) w[j] <= field[j];
                        addr <= ADDR_WIDTH'(1);
                    end
                end
                S_FETCH: begin
                    if (s_valid) begin
                        y_r <= field[0];
                        for (int k = 1; k <= MAX_FEATURES; k++) x_r[k] <= field[k];
                    end
                end
                S_PRED: begin
                    err_out <= err_calc;
                end
                S_UPDATE: begin
                    for (int j = 0; j < NF; j++) w[j] <= w_upd[j];
                    if (sample_last) begin
                        addr      <= ADDR_WIDTH'(1);
                        epoch_cnt <= epoch_cnt + 8'd1;
                    end else begin
                        addr <= addr + ADDR_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sgd_trainer_v4.sv
// tb/tb_sgd_trainer_v4.sv - scoreboard bench: directed runs, monitors check fetch addresses and end-of-run results
`timescale 1ns/1ps
module tb_sgd_trainer_v4;

    localparam int LENGTH = 16;
    localparam int FRAC   = 8;
    localparam int MAXF   = 15;
    localparam int AW     = 12;
    localparam int DW     = LENGTH * (MAXF + 1);

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [3:0]      feat = '0;
    logic [AW-1:0]   data_points = '0;
    logic [7:0]      epoch = '0;
    logic [3:0]      learn_rate = '0;
    logic [DW-1:0]   s_data;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [AW-1:0]   addr;
    logic [3:0]      w_sel = '0;
    logic [15:0]     w_rdata;
    logic            busy;
    logic            done;
    logic [15:0]     err_out;

    logic [DW-1:0]   mem [0:7];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_hs_cyc = 0;

    typedef struct packed {
        logic            done;
        logic [15:0]     err;
        logic [2:0]      n;
        logic [3:0][3:0] idx;
        logic [3:0][15:0] val;
    } exp_t;

    exp_t          exp_q [$];
    logic [AW-1:0] addr_q [$];
    exp_t          e;
    logic          busy_d = 1'b0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    assign s_data = mem[addr[2:0]];

    sgd_trainer_v4 #(
        .LENGTH       (LENGTH),
        .FRAC         (FRAC),
        .MAX_FEATURES (MAXF),
        .ADDR_WIDTH   (AW)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .abort       (abort),
        .feat        (feat),
        .data_points (data_points),
        .epoch       (epoch),
        .learn_rate  (learn_rate),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .addr        (addr),
        .w_sel       (w_sel),
        .w_rdata     (w_rdata),
        .busy        (busy),
        .done        (done),
        .err_out     (err_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [15:0] f0, input logic [15:0] f1,
                                         input logic [15:0] f2, input logic [15:0] f3,
                                         input logic [15:0] f15);
        logic [DW-1:0] v;
        v = '0;
        v[DW-1  -: 16] = f0;
        v[DW-17 -: 16] = f1;
        v[DW-33 -: 16] = f2;
        v[DW-49 -: 16] = f3;
        v[15:0]        = f15;
        return v;
    endfunction

    function automatic exp_t mkexp(input logic d, input logic [15:0] er, input logic [2:0] n,
                                   input logic [3:0] i0, input logic [15:0] v0,
                                   input logic [3:0] i1, input logic [15:0] v1,
                                   input logic [3:0] i2, input logic [15:0] v2,
                                   input logic [3:0] i3, input logic [15:0] v3);
        exp_t r;
        r.done   = d;
        r.err    = er;
        r.n      = n;
        r.idx[0] = i0; r.val[0] = v0;
        r.idx[1] = i1; r.val[1] = v1;
        r.idx[2] = i2; r.val[2] = v2;
        r.idx[3] = i3; r.val[3] = v3;
        return r;
    endfunction

    // Every accepted word must come from the next expected address.
    always @(negedge CLK) begin
        if (RST && s_valid && s_ready) begin
            last_hs_cyc = cyc;
            if (addr_q.size() == 0) chk("hs_unexpected", 32'(addr), 32'hFFFF_FFFF);
            else chk("hs_addr", 32'(addr), 32'(addr_q.pop_front()));
        end
    end

    // When the block stops being busy, compare status and read back the expected weights.
    always @(negedge CLK) begin
        if (busy_d && !busy) begin
            if (exp_q.size() == 0) begin
                chk("busy_fall_unexpected", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("done", 32'(done), 32'(e.done));
                chk("err_out", 32'(err_out), 32'(e.err));
                for (int i = 0; i < 4; i++) begin
                    if (i < int'(e.n)) begin
                        w_sel = e.idx[i];
                        #0.2;
                        chk($sformatf("w_rdata[%0d]", e.idx[i]), 32'(w_rdata), 32'(e.val[i]));
                    end
                end
            end
        end
        busy_d = busy;
    end

    task automatic run_start(input logic [3:0] f, input logic [AW-1:0] dp,
                             input logic [7:0] ep, input logic [3:0] lr);
        feat = f; data_points = dp; epoch = ep; learn_rate = lr;
        @(posedge CLK); #1 start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int lim, input string name, output int dc);
        dc = -1;
        for (int k = 0; k < lim; k++) begin
            @(negedge CLK);
            if (!busy) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) chk({name, "_timeout"}, 32'(1), 32'(0));
        @(posedge CLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dc;
        int t0;
        for (int i = 0; i < 8; i++) mem[i] = '0;

        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy",  32'(busy),    32'(0));
        chk("rst_done",  32'(done),    32'(0));
        chk("rst_ready", 32'(s_ready), 32'(0));
        chk("rst_addr",  32'(addr),    32'(0));
        chk("rst_err",   32'(err_out), 32'(0));
        RST = 1'b1;
        @(posedge CLK); #1;

        // Single sample from zero weights.
        mem[0] = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        mem[1] = mk(16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0000);
        addr_q.push_back(0); addr_q.push_back(1);
        exp_q.push_back(mkexp(1'b1, 16'h0100, 3'd3, 4'd0, 16'h0100, 4'd1, 16'h0100, 4'd2, 16'h0000, 4'd0, 16'h0000));
        s_valid = 1'b1;
        run_start(4'd1, 12'd1, 8'd1, 4'd0);
        wait_idle(50, "t1", dc);

        // Two epochs of three samples, learn_rate 1, lane 1 disabled; a stray start while busy.
        mem[0] = mk(16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000);
        for (int i = 1; i <= 3; i++) mem[i] = mk(16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0000);
        addr_q.push_back(0);
        for (int r = 0; r < 2; r++) begin
            addr_q.push_back(1); addr_q.push_back(2); addr_q.push_back(3);
        end
        exp_q.push_back(mkexp(1'b1, 16'h0008, 3'd2, 4'd0, 16'h00FC, 4'd1, 16'h0100, 4'd0, 16'h0000, 4'd0, 16'h0000));
        run_start(4'd0, 12'd3, 8'd2, 4'd1);
        repeat (4) begin @(posedge CLK); #1; end
        start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        wait_idle(100, "t2", dc);
        chk("t2_done_latency", 32'(dc - last_hs_cyc), 32'(3));

        // epoch 0: only the weight word is read.
        mem[0] = mk(16'h0123, 16'h0456, 16'h0000, 16'h0000, 16'h0ABC);
        addr_q.push_back(0);
        exp_q.push_back(mkexp(1'b1, 16'h0008, 3'd4, 4'd0, 16'h0123, 4'd1, 16'h0456, 4'd15, 16'h0ABC, 4'd2, 16'h0000));
        run_start(4'd15, 12'd2, 8'd0, 4'd0);
        wait_idle(20, "t3", dc);
        chk("t3_addr", 32'(addr), 32'(1));

        // s_valid low for 5 FETCH cycles; lane 3 inactive.
        mem[0] = mk(16'h0000, 16'h0200, 16'h0080, 16'h0111, 16'h0000);
        mem[1] = mk(16'h0400, 16'h0100, 16'h0200, 16'h0100, 16'h0000);
        addr_q.push_back(0); addr_q.push_back(1);
        exp_q.push_back(mkexp(1'b1, 16'h0100, 3'd4, 4'd0, 16'h0100, 4'd1, 16'h0300, 4'd2, 16'h0280, 4'd3, 16'h0111));
        run_start(4'd2, 12'd1, 8'd1, 4'd0);
        @(posedge CLK); #1 s_valid = 1'b0;
        t0 = cyc;
        repeat (5) begin
            @(negedge CLK);
            chk("t4_stall_ready", 32'(s_ready), 32'(1));
            chk("t4_stall_addr",  32'(addr),    32'(1));
            @(posedge CLK); #1;
        end
        s_valid = 1'b1;
        wait_idle(50, "t4", dc);
        chk("t4_sample_cycles", 32'(dc - t0), 32'(8));

        // W0 overflow on the weight update.
        mem[0] = mk(16'h7F00, 16'h8100, 16'h0000, 16'h0000, 16'h0000);
        mem[1] = mk(16'h7FFF, 16'h0100, 16'h0000, 16'h0000, 16'h0000);
        addr_q.push_back(0); addr_q.push_back(1);
`ifdef SGD_SATURATE_EN
        exp_q.push_back(mkexp(1'b1, 16'h7FFF, 3'd2, 4'd0, 16'h7FFF, 4'd1, 16'h00FF, 4'd0, 16'h0000, 4'd0, 16'h0000));
`else
        exp_q.push_back(mkexp(1'b1, 16'h7FFF, 3'd2, 4'd0, 16'hFEFF, 4'd1, 16'h00FF, 4'd0, 16'h0000, 4'd0, 16'h0000));
`endif
        run_start(4'd1, 12'd1, 8'd1, 4'd0);
        wait_idle(50, "t5", dc);

        // Abort during the UPDATE of sample 2.
        mem[0] = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        mem[1] = mk(16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        mem[2] = mk(16'h0300, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        addr_q.push_back(0); addr_q.push_back(1); addr_q.push_back(2);
        exp_q.push_back(mkexp(1'b0, 16'h0200, 3'd1, 4'd0, 16'h0100, 4'd0, 16'h0000, 4'd0, 16'h0000, 4'd0, 16'h0000));
        run_start(4'd0, 12'd2, 8'd1, 4'd0);
        repeat (6) begin @(posedge CLK); #1; end
        abort = 1'b1;
        @(posedge CLK); #1 abort = 1'b0;
        chk("t6_busy", 32'(busy), 32'(0));
        chk("t6_addr", 32'(addr), 32'(0));
        chk("t6_ready", 32'(s_ready), 32'(0));
        wait_idle(5, "t6", dc);

        // Reset while waiting in FETCH.
        mem[0] = mk(16'h0555, 16'h0666, 16'h0000, 16'h0000, 16'h0000);
        addr_q.push_back(0);
        exp_q.push_back(mkexp(1'b0, 16'h0000, 3'd2, 4'd0, 16'h0000, 4'd1, 16'h0000, 4'd0, 16'h0000, 4'd0, 16'h0000));
        run_start(4'd1, 12'd1, 8'd1, 4'd0);
        @(posedge CLK); #1 s_valid = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
        chk("t7_in_fetch", 32'(s_ready), 32'(1));
        RST = 1'b0;
        wait_idle(5, "t7", dc);
        chk("t7_ready", 32'(s_ready), 32'(0));
        chk("t7_addr",  32'(addr),    32'(0));
        chk("t7_err",   32'(err_out), 32'(0));
        RST = 1'b1;
        @(posedge CLK); #1;

        chk("addr_q_drained", 32'(addr_q.size()), 32'(0));
        chk("exp_q_drained",  32'(exp_q.size()),  32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
